// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle for fifo_wr_arbiter.
// The master modport is the environment side (requesters plus FIFO), and the slave modport is the arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [IDW-1:0]                gnt_id;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_wr_ack;
  logic                          ack_err;

  modport master (
    output req, req_data, fifo_full, fifo_wr_ack,
    input  gnt, gnt_id, fifo_wr_en, fifo_data_in, ack_err
  );

  modport slave (
    input  req, req_data, fifo_full, fifo_wr_ack,
    output gnt, gnt_id, fifo_wr_en, fifo_data_in, ack_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port and checks the FIFO write acknowledge.
// Define FIFO_ARB_BURST_EN to build the optional burst-lock mode, which allows up to MAX_BURST beats per grant.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  typedef logic [IDW-1:0] id_t;

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be 2..16");
  end
  if (MAX_BURST < 2 || MAX_BURST > 16) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be 2..16");
  end

  function automatic id_t next_id(id_t i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + id_t'(1);
  endfunction

  // {found, index} of the first set request at or after b, wrapping modulo NUM_REQ
  function automatic logic [IDW:0] first_from(logic [NUM_REQ-1:0] r, id_t b);
    logic [IDW:0] res;
    int unsigned  idx;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(b) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!res[IDW] && r[id_t'(idx)]) res = {1'b1, id_t'(idx)};
    end
    return res;
  endfunction

  id_t          rr_ptr, rr_ptr_next, base, grant_id;
  logic         grant_v;
  logic [IDW:0] search;
  logic         ack_pend, ack_err_q;

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {ARB, LOCK} state_t;

  state_t          state, state_next;
  id_t             owner, owner_next;
  logic [BW-1:0]   beat_cnt, beat_next;
  logic            owner_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      beat_cnt <= beat_next;
      rr_ptr   <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next  = state;
    owner_next  = owner;
    beat_next   = beat_cnt;
    rr_ptr_next = rr_ptr;
    if (grant_v && owner_hold) begin
      if (beat_cnt == BW'(MAX_BURST - 1)) begin
        state_next  = ARB;
        beat_next   = '0;
        rr_ptr_next = next_id(owner);
      end else begin
        beat_next = beat_cnt + BW'(1);
      end
    end else if (grant_v) begin
      // A new grant also covers a lock that was released in the same cycle, so rr_ptr takes the effective base.
      state_next  = LOCK;
      owner_next  = grant_id;
      beat_next   = BW'(1);
      rr_ptr_next = base;
    end else if (state == LOCK && !bus.req[owner] && !bus.fifo_full) begin
      state_next  = ARB;
      beat_next   = '0;
      rr_ptr_next = next_id(owner);
    end
  end

  always_comb begin
    owner_hold = (state == LOCK) && bus.req[owner];
    base       = (state == LOCK && !owner_hold) ? next_id(owner) : rr_ptr;
    search     = first_from(bus.req, base);
    grant_v    = rst_n && !bus.fifo_full && (owner_hold || search[IDW]);
    grant_id   = owner_hold ? owner : search[IDW-1:0];
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= '0;
    else        rr_ptr <= rr_ptr_next;
  end

  always_comb begin
    base        = rr_ptr;
    search      = first_from(bus.req, base);
    grant_v     = rst_n && !bus.fifo_full && search[IDW];
    grant_id    = search[IDW-1:0];
    rr_ptr_next = grant_v ? next_id(grant_id) : rr_ptr;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pend  <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      ack_pend <= grant_v;
      if (ack_pend && !bus.fifo_wr_ack) ack_err_q <= 1'b1;
    end
  end

  always_comb begin
    bus.gnt          = '0;
    bus.gnt_id       = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_data_in = '0;
    bus.ack_err      = ack_err_q;
    if (grant_v) begin
      bus.gnt          = NUM_REQ'(1) << grant_id;
      bus.gnt_id       = grant_id;
      bus.fifo_wr_en   = 1'b1;
      bus.fifo_data_in = bus.req_data[grant_id*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end
endmodule
